// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
  localparam int DATA_SIZE        = 64;
  localparam int INSTRUCTION_SIZE = 32;

  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    DROP
  } fetch_state_e;

  typedef struct packed {
    logic [INSTRUCTION_SIZE-1:0] instruction;
    logic [DATA_SIZE-1:0]        pc;
    logic                        branch_taken;
    logic [DATA_SIZE-1:0]        pred_target;
  } fetch_packet_t;
endpackage

// File: rtl/static_predictor.sv
// Combinational static predictor: JAL and backward conditional branches are taken,
// everything else falls through to pc+4.
module static_predictor
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = DATA_SIZE
) (
  input  logic [INSTRUCTION_SIZE-1:0] instruction,
  input  logic [ADDR_WIDTH-1:0]       pc,
  output logic                        taken,
  output logic [ADDR_WIDTH-1:0]       target
);
  logic [ADDR_WIDTH-1:0] imm_j;
  logic [ADDR_WIDTH-1:0] imm_b;

  assign imm_j = {{(ADDR_WIDTH-20){instruction[31]}}, instruction[19:12], instruction[20],
                  instruction[30:21], 1'b0};
  assign imm_b = {{(ADDR_WIDTH-12){instruction[31]}}, instruction[7], instruction[30:25],
                  instruction[11:8], 1'b0};

  always_comb begin
    taken  = 1'b0;
    target = pc + ADDR_WIDTH'(4);
    if (instruction[6:0] == OPCODE_JAL) begin
      taken  = 1'b1;
      target = pc + imm_j;
    end else if (instruction[6:0] == OPCODE_BRANCH && instruction[31]) begin
      taken  = 1'b1;
      target = pc + imm_b;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC ownership, one-outstanding imem requests, output register
// plus one-entry skid buffer. Static prediction is enabled by FETCH_STATIC_PREDICT_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [DATA_SIZE-1:0] RESET_PC   = 64'h0,
  parameter int                   ADDR_WIDTH = DATA_SIZE
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        redirect_valid,
  input  logic [ADDR_WIDTH-1:0]       redirect_pc,
  output logic                        imem_req_valid,
  output logic [ADDR_WIDTH-1:0]       imem_req_addr,
  input  logic                        imem_req_ready,
  input  logic                        imem_resp_valid,
  input  logic [INSTRUCTION_SIZE-1:0] imem_resp_data,
  output logic                        out_valid,
  output logic [INSTRUCTION_SIZE-1:0] out_instruction,
  output logic [ADDR_WIDTH-1:0]       out_pc,
  output logic                        out_branch_taken,
  output logic [ADDR_WIDTH-1:0]       out_pred_target
);
  fetch_state_e          state_reg, state_next;
  logic [ADDR_WIDTH-1:0] pc_reg, pc_next;
  fetch_packet_t         out_reg, out_next, skid_reg, skid_next, resp_pkt;
  logic                  out_valid_reg, out_valid_next, skid_valid_reg, skid_valid_next;
  logic                  pred_taken;
  logic [ADDR_WIDTH-1:0] pred_target;
  logic                  out_free, resp_accept;

`ifdef FETCH_STATIC_PREDICT_EN
  static_predictor #(.ADDR_WIDTH(ADDR_WIDTH)) u_predictor (
    .instruction(imem_resp_data),
    .pc         (pc_reg),
    .taken      (pred_taken),
    .target     (pred_target)
  );
`else
  assign pred_taken  = 1'b0;
  assign pred_target = pc_reg + ADDR_WIDTH'(4);
`endif

  assign resp_pkt = '{instruction: imem_resp_data, pc: pc_reg,
                      branch_taken: pred_taken, pred_target: pred_target};

  assign imem_req_valid = (state_reg == FETCH) && !skid_valid_reg && !redirect_valid && !reset;
  assign imem_req_addr  = pc_reg;
  assign out_free       = !out_valid_reg || !stall;
  assign resp_accept    = (state_reg == WAIT) && imem_resp_valid;

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    out_next        = out_reg;
    out_valid_next  = out_valid_reg;
    skid_next       = skid_reg;
    skid_valid_next = skid_valid_reg;
    if (redirect_valid) begin
      out_valid_next  = 1'b0;
      skid_valid_next = 1'b0;
      pc_next         = redirect_pc;
      // An outstanding request either answers now (dropped here) or must be drained in DROP.
      if (state_reg == WAIT || state_reg == DROP) begin
        state_next = imem_resp_valid ? FETCH : DROP;
      end else begin
        state_next = FETCH;
      end
    end else begin
      if (out_free) begin
        if (skid_valid_reg) begin
          out_next        = skid_reg;
          out_valid_next  = 1'b1;
          skid_valid_next = 1'b0;
        end else if (resp_accept) begin
          out_next       = resp_pkt;
          out_valid_next = 1'b1;
        end else begin
          out_valid_next = 1'b0;
        end
      end else if (resp_accept) begin
        skid_next       = resp_pkt;
        skid_valid_next = 1'b1;
      end
      case (state_reg)
        FETCH: if (imem_req_valid && imem_req_ready) state_next = WAIT;
        WAIT: begin
          if (imem_resp_valid) begin
            state_next = FETCH;
            pc_next    = resp_pkt.pred_target;
          end
        end
        DROP: if (imem_resp_valid) state_next = FETCH;
        default: state_next = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= FETCH;
      pc_reg         <= RESET_PC;
      out_reg        <= '0;
      out_valid_reg  <= 1'b0;
      skid_reg       <= '0;
      skid_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      out_reg        <= out_next;
      out_valid_reg  <= out_valid_next;
      skid_reg       <= skid_next;
      skid_valid_reg <= skid_valid_next;
    end
  end

  assign out_valid        = out_valid_reg;
  assign out_instruction  = out_reg.instruction;
  assign out_pc           = out_reg.pc;
  assign out_branch_taken = out_reg.branch_taken;
  assign out_pred_target  = out_reg.pred_target;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit and static_predictor: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a queue-based behavioural model.
module tb_fetch_unit;
  localparam logic [63:0] RST_PC = 64'h1000;
`ifdef FETCH_STATIC_PREDICT_EN
  localparam bit PRED_ON = 1'b1;
`else
  localparam bit PRED_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid, imem_req_ready, imem_resp_valid;
  logic [63:0] redirect_pc;
  logic [31:0] imem_resp_data;
  logic        imem_req_valid, out_valid, out_branch_taken;
  logic [63:0] imem_req_addr, out_pc, out_pred_target;
  logic [31:0] out_instruction;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC), .ADDR_WIDTH(64)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .out_valid(out_valid),
    .out_instruction(out_instruction), .out_pc(out_pc),
    .out_branch_taken(out_branch_taken), .out_pred_target(out_pred_target)
  );

  logic [31:0] sp_instr;
  logic [63:0] sp_pc, sp_target;
  logic        sp_taken;
  static_predictor #(.ADDR_WIDTH(64)) u_sp (
    .instruction(sp_instr), .pc(sp_pc), .taken(sp_taken), .target(sp_target)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference prediction built from the immediate field definitions with plain arithmetic.
  function automatic void ref_predict(input logic [31:0] i, input logic [63:0] pc,
                                      output logic t, output logic [63:0] tgt);
    longint imm;
    t   = 1'b0;
    tgt = pc + 64'd4;
    if (i[6:0] == 7'h6F) begin
      imm = (longint'(i[31]) << 20) + (longint'(i[19:12]) << 12) +
            (longint'(i[20]) << 11) + (longint'(i[30:21]) << 1);
      if (i[31]) imm = imm - (longint'(1) << 21);
      t   = 1'b1;
      tgt = pc + 64'(imm);
    end else if (i[6:0] == 7'h63 && i[31]) begin
      imm = (longint'(1) << 12) + (longint'(i[7]) << 11) +
            (longint'(i[30:25]) << 5) + (longint'(i[11:8]) << 1);
      imm = imm - (longint'(1) << 13);
      t   = 1'b1;
      tgt = pc + 64'(imm);
    end
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic        taken;
    logic [63:0] target;
  } pkt_t;

  pkt_t        q[$];
  logic [63:0] m_pc;
  bit          m_out, m_discard, exp_req, acc;

  bit          mem_pend, force_en, rdy_rand;
  int          mem_cnt, lat;
  logic [31:0] mem_data, force_data;

  function automatic logic [31:0] gen_data();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: r = 32'h0000_0013;
      1: begin r[6:0] = 7'h63; r[31] = 1'b1; end
      2: begin r[6:0] = 7'h63; r[31] = 1'b0; end
      3: r[6:0] = 7'h6F;
      4: r[6:0] = 7'h67;
      default: ;
    endcase
    return r;
  endfunction

  function automatic void model_reset();
    q.delete();
    m_pc      = RST_PC;
    m_out     = 1'b0;
    m_discard = 1'b0;
  endfunction

  // One clock: compare at negedge, advance model and memory at posedge, drive memory after.
  task automatic cycle();
    pkt_t p;
    bit   issue;
    @(negedge clk);
    exp_req = !m_out && (q.size() < 2) && !redirect_valid && !reset;
    check("req_valid", imem_req_valid, exp_req);
    check("req_addr", imem_req_addr, m_pc);
    check("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      check("out_instruction", out_instruction, q[0].instr);
      check("out_pc", out_pc, q[0].pc);
      check("out_branch_taken", out_branch_taken, q[0].taken);
      check("out_pred_target", out_pred_target, q[0].target);
    end
    acc = imem_req_valid && imem_req_ready;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else if (redirect_valid) begin
      q.delete();
      m_pc = redirect_pc;
      if (m_out) begin
        if (imem_resp_valid) begin
          m_out     = 1'b0;
          m_discard = 1'b0;
        end else begin
          m_discard = 1'b1;
        end
      end
    end else begin
      issue = exp_req && imem_req_ready;
      if (q.size() > 0 && !stall) begin
        $display("deliver pc=%h instr=%h taken=%0d target=%h",
                 q[0].pc, q[0].instr, q[0].taken, q[0].target);
        void'(q.pop_front());
      end
      if (m_out && imem_resp_valid) begin
        m_out = 1'b0;
        if (m_discard) begin
          m_discard = 1'b0;
        end else begin
          p.instr = imem_resp_data;
          p.pc    = m_pc;
          if (PRED_ON) ref_predict(imem_resp_data, m_pc, p.taken, p.target);
          else begin p.taken = 1'b0; p.target = m_pc + 64'd4; end
          q.push_back(p);
          m_pc = p.target;
        end
      end else if (issue) begin
        m_out = 1'b1;
      end
    end
    if (imem_resp_valid) mem_pend = 1'b0;
    if (acc) begin
      mem_pend = 1'b1;
      mem_cnt  = lat - 1;
      mem_data = force_en ? force_data : gen_data();
    end else if (mem_pend && mem_cnt > 0) begin
      mem_cnt--;
    end
    #1;
    imem_resp_valid = mem_pend && (mem_cnt == 0);
    imem_resp_data  = imem_resp_valid ? mem_data : $urandom;
    imem_req_ready  = !mem_pend && (rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
  endtask

  task automatic directed(input logic [63:0] addr, input logic [31:0] data,
                          input logic exp_t, input logic [63:0] exp_tgt);
    bit found;
    found          = 1'b0;
    force_data     = data;
    redirect_valid = 1'b1;
    redirect_pc    = addr;
    cycle();
    redirect_valid = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      cycle();
      #1;
      if (out_valid && out_pc == addr) found = 1'b1;
    end
    check("directed_arrival", found, 1'b1);
    if (found) begin
      check("directed_instr", out_instruction, data);
      check("directed_taken", out_branch_taken, exp_t);
      check("directed_target", out_pred_target, exp_tgt);
      check("directed_next_req", imem_req_addr, exp_tgt);
    end
  endtask

  logic [31:0] t_instr [8] = '{32'h0000_0013, 32'hFE00_0EE3, 32'h0080_00EF, 32'h0000_80E7,
                               32'h0000_0463, 32'hFFDF_F06F, 32'h8000_0063, 32'h7FFF_F06F};
  logic [63:0] t_pc    [8] = '{64'h1000, 64'h2000, 64'h3000, 64'h3000,
                               64'h100, 64'h0, 64'h5000, 64'hFFFF_FFFF_FFFF_FFF0};
  logic        t_taken [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [63:0] t_tgt   [8] = '{64'h1004, 64'h1FFC, 64'h3008, 64'h3004,
                               64'h104, 64'hFFFF_FFFF_FFFF_FFFC, 64'h4000, 64'hF_FFEE};

  initial begin
    logic        rt;
    logic [63:0] rtgt;
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
    mem_pend = 1'b0; mem_cnt = 0; mem_data = '0; lat = 1; rdy_rand = 1'b0;
    force_en = 1'b1; force_data = 32'h0000_0013;
    sp_instr = '0; sp_pc = '0;

    // Predictor unit checks; the same literals also pin the bench's reference function.
    for (int i = 0; i < 8; i++) begin
      sp_instr = t_instr[i];
      sp_pc    = t_pc[i];
      #1;
      check("sp_taken", sp_taken, t_taken[i]);
      check("sp_target", sp_target, t_tgt[i]);
      ref_predict(t_instr[i], t_pc[i], rt, rtgt);
      check("ref_taken", rt, t_taken[i]);
      check("ref_target", rtgt, t_tgt[i]);
    end

    repeat (2) @(posedge clk);
    model_reset();
    #1 reset = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_instruction", out_instruction, 64'h0);
    check("rst_out_pc", out_pc, 64'h0);
    check("rst_out_taken", out_branch_taken, 1'b0);
    check("rst_out_target", out_pred_target, 64'h0);
    check("rst_req_addr", imem_req_addr, 64'h1000);
    check("rst_req_valid", imem_req_valid, 1'b1);

    cycle();
    cycle();
    #1;
    check("nop_out_valid", out_valid, 1'b1);
    check("nop_out_pc", out_pc, 64'h1000);
    check("nop_taken", out_branch_taken, 1'b0);
    check("nop_next_req", imem_req_addr, 64'h1004);

    directed(64'h2000, 32'hFE00_0EE3, PRED_ON, PRED_ON ? 64'h1FFC : 64'h2004);
    directed(64'h3000, 32'h0080_00EF, PRED_ON, PRED_ON ? 64'h3008 : 64'h3004);

    // Stall held across two responses: head held, second in skid, requests blocked.
    force_data = 32'h0000_0013;
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h4000;
    cycle();
    redirect_valid = 1'b0;
    repeat (6) cycle();
    #1;
    check("stall_out_valid", out_valid, 1'b1);
    check("stall_out_pc", out_pc, 64'h4000);
    check("stall_no_req", imem_req_valid, 1'b0);
    stall = 1'b0;
    cycle();
    #1;
    check("skid_out_pc", out_pc, 64'h4004);
    check("skid_out_valid", out_valid, 1'b1);

    // Redirect in WAIT with the stale response arriving one cycle later.
    lat = 2; force_data = 32'hDEAD_BEEF;
    redirect_valid = 1'b1; redirect_pc = 64'h6000;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    redirect_valid = 1'b1; redirect_pc = 64'h5000;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    #1;
    check("drop_out_valid", out_valid, 1'b0);
    check("drop_req_valid", imem_req_valid, 1'b1);
    check("drop_req_addr", imem_req_addr, 64'h5000);

    // Redirect coinciding with the response.
    lat = 1;
    cycle();
    redirect_valid = 1'b1; redirect_pc = 64'h5000;
    cycle();
    redirect_valid = 1'b0;
    #1;
    check("same_out_valid", out_valid, 1'b0);
    check("same_req_valid", imem_req_valid, 1'b1);
    check("same_req_addr", imem_req_addr, 64'h5000);

    // Reset while a request is outstanding; its late response must be ignored.
    lat = 2;
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    #1;
    check("wreset_out_valid", out_valid, 1'b0);
    check("wreset_req_addr", imem_req_addr, RST_PC);
    repeat (4) cycle();

    force_en = 1'b0; rdy_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      lat            = $urandom_range(1, 3);
      stall          = ($urandom_range(0, 99) < 30);
      redirect_valid = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 3) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 3) * 4);
      else redirect_pc = {$urandom, $urandom} & ~64'h3;
      reset          = ($urandom_range(0, 999) < 5);
      cycle();
    end
    reset = 1'b0; redirect_valid = 1'b0; stall = 1'b0;
    repeat (5) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage. It feeds the decode stage its 32-bit `instruction` and its `branch_taken` prediction bit.
- It owns the PC, issues one-at-a-time requests to instruction memory and buffers responses across decode stalls.
- It applies a static branch prediction and accepts redirects from execute on mispredict or JALR.

Parameters:
RESET_PC, 64'h0, PC loaded on reset.
ADDR_WIDTH, 64 (= `DATA_SIZE`), PC and memory address width.

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high
stall  in  1  decode cannot accept this cycle
redirect_valid  in  1  execute redirect (mispredict/JALR)
redirect_pc  in  ADDR_WIDTH  redirect target
imem_req_valid  out  1  request valid
imem_req_addr  out  ADDR_WIDTH  request address (current PC)
imem_req_ready  in  1  memory accepts request
imem_resp_valid  in  1  response valid; arrives at least 1 cycle after acceptance
imem_resp_data  in  `INSTRUCTION_SIZE`  fetched instruction
out_valid  out  1  instruction valid to decode
out_instruction  out  `INSTRUCTION_SIZE`  to decoder instruction
out_pc  out  ADDR_WIDTH  PC of out_instruction
out_branch_taken  out  1  to decoder branch_taken
out_pred_target  out  ADDR_WIDTH  predicted next PC

Behaviour:

States:
- FETCH: may issue a request.
- WAIT: one request outstanding.
- DROP: one outstanding request whose response must be discarded.

Reset:
- state=FETCH, pc=RESET_PC, skid empty.
- out_valid=0; out_instruction, out_pc, out_branch_taken and out_pred_target all 0.

Request side:
- imem_req_valid = (state==FETCH) && !skid_valid && !redirect_valid && !reset. It is combinational.
- imem_req_addr = pc.
- valid&&ready moves to WAIT. At most one request is outstanding.

Output consumption:
- The output register is consumed when out_valid && !stall.
- out_* hold stable while out_valid && stall.

Response in WAIT:
- Compute the prediction from resp_data and pc (see below).
- If the output register is empty or consumed this cycle, load out_* and set out_valid=1 next cycle. Otherwise write the one-entry skid buffer.
- pc <= predicted next PC; state -> FETCH.

Skid buffer:
- Moves into the output register on the first cycle the output register is empty or consumed.
- While the skid buffer is full, no requests are issued.

Prediction, with rs = resp_data:
- opcode 1101111 (JAL): taken, target = pc + imm_j.
- opcode 1100011 with rs[31]=1 (backward branch): taken, target = pc + imm_b.
- All else, including JALR: not taken, target = pc+4.
- imm_j and imm_b are sign-extended to 64 bits with the RV64 bit layouts.
- All PC arithmetic is modulo 2^ADDR_WIDTH; wrap-around is silent.

Redirect (highest priority after reset):
- Clears out_valid and the skid buffer; pc <= redirect_pc.
- FETCH: request suppressed this cycle; stay FETCH.
- WAIT without a response this cycle: go DROP.
- WAIT with a response the same cycle: discard it, go FETCH.
- DROP: stay DROP; pc takes the newest redirect_pc.

DROP:
- The next imem_resp_valid is discarded and the state goes to FETCH.
- pc is unchanged by the discarded response.

Other boundary rules:
- imem_resp_valid outside WAIT/DROP is ignored.
- reset mid-operation overrides everything; an outstanding response arriving after reset is ignored.

Optional Feature:
FETCH_STATIC_PREDICT_EN
- Defined: the prediction rules above apply.
- Undefined: out_branch_taken is always 0 and the next PC is always pc+4, including for JAL; execute corrects via redirect.

Decomposition:
- Shared package `fetch_pkg`:
  - fetch_state_e (FETCH/WAIT/DROP).
  - OPCODE_JAL=7'b1101111, OPCODE_BRANCH=7'b1100011.
  - fetch_packet_t {instruction, pc, branch_taken, pred_target}, used by the output register and the skid buffer.
- Sub-module `static_predictor`: combinational; inputs instruction and pc, outputs taken and target. It gets its own unit test.

Test Plan:
1. Reset with RESET_PC=0x1000, then ready=1 and a response 1 cycle after each acceptance with data 0x00000013 (NOP) -> imem_req_addr 0x1000, then 0x1004; out_pc 0x1000 with branch_taken=0.
2. Response 0xFE000EE3 (BEQ, offset -4) at pc 0x2000 -> out_branch_taken=1, out_pred_target=0x1FFC, next req addr 0x1FFC. With the macro undefined -> taken=0, next addr 0x2004.
3. JAL 0x008000EF at pc 0x3000 -> taken=1, target 0x3008.
4. stall held 5 cycles during two responses -> first instruction is held stable in out_*, the second goes to the skid buffer, no third request is issued. After release they come out in order, one per cycle.
5. Redirect to 0x5000 while in WAIT, stale response 0xDEADBEEF next cycle -> stale response discarded, out_valid stays 0, next req addr 0x5000.
6. Redirect in the same cycle as a response in WAIT -> response dropped, req 0x5000 on the following cycle. reset asserted in WAIT -> out_valid=0, req addr RESET_PC.
